// File: rtl/beta_alu_issue.sv
// Issue/writeback controller for the combinational Beta ALU: decodes one
// OP/OPC instruction at a time, reads the register file, drives the ALU, writes back.
module beta_alu_issue #(
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [3:0]  alu_fn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        retire,
  output logic [4:0]  retire_rc,
  output logic [31:0] retire_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t             state, state_nxt;
  logic [31:0]        inst_q;
  logic [31:0]        rf [0:30];
  logic [2:0]         wait_cnt;

  logic [5:0]         opcode;
  logic [4:0]         rc, ra, rb;
  logic [31:0]        ra_val, rb_val;
  logic signed [31:0] lit_sx;
  logic               legal;

  // DIV, 0x7 and 0xF function codes have no ALU implementation
  function automatic logic is_legal(input logic [5:0] op);
    return op[5] && (op[3:0] != 4'h3) && (op[3:0] != 4'h7) && (op[3:0] != 4'hF);
  endfunction

  assign opcode = inst_q[31:26];
  assign rc     = inst_q[25:21];
  assign ra     = inst_q[20:16];
  assign rb     = inst_q[15:11];
  assign lit_sx = {{16{inst_q[15]}}, inst_q[15:0]};
  assign legal  = is_legal(opcode);

  // R31 is hardwired to zero and has no storage
  assign ra_val   = (ra == 5'd31)       ? '0 : rf[ra];
  assign rb_val   = (rb == 5'd31)       ? '0 : rf[rb];
  assign dbg_data = (dbg_addr == 5'd31) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inst_valid) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : IDLE;
      EXEC:    if (wait_cnt == 3'd0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      alu_fn      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wait_cnt    <= '0;
      retire      <= 1'b0;
      retire_rc   <= '0;
      retire_data <= '0;
      illegal     <= 1'b0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (inst_valid) inst_q <= inst;
        DECODE: begin
          if (legal) begin
            alu_fn   <= opcode[3:0];
            alu_a    <= ra_val;
            alu_b    <= opcode[4] ? lit_sx : rb_val;
            wait_cnt <= 3'(ALU_WAIT);
          end else begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          // retire is raised here so that it is high exactly during WB
          if (wait_cnt == 3'd0) begin
            retire      <= 1'b1;
            retire_rc   <= rc;
            retire_data <= alu_result;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) rf[i] <= '0;
    end else if (state == WB && retire_rc != 5'd31) begin
      rf[retire_rc] <= retire_data;
    end
  end

endmodule
